// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory-port arbiter state encoding, owner codes,
// default bus widths and a counter-width helper.
package cpu_pkg;

  localparam int unsigned DEF_AW = 8;
  localparam int unsigned DEF_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_D  = 1'b1;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// Loadable down-counter with a zero flag; times the memory read latency.
module lat_counter #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero_c
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one fixed-latency memory port between instruction
// fetch and the data stage. Data has priority; a run-length guard protects fetch.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned AW        = DEF_AW,
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned MEM_LAT   = 2,
  parameter int unsigned MAX_D_RUN = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          d_stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner
);

  localparam int unsigned   LW       = cnt_width(MEM_LAT - 1);
  localparam int unsigned   RW       = cnt_width(MAX_D_RUN);
  localparam logic [LW-1:0] LAT_LOAD = LW'(MEM_LAT - 1);
  localparam logic [RW-1:0] RUN_MAX  = RW'(MAX_D_RUN);

  arb_state_e    state;
  logic [RW-1:0] run_cnt;
  logic          d_grant_c;
  logic          lat_load_c;
  logic          lat_dec_c;
  logic          lat_zero_c;

  // Data wins unless fetch has been waiting through a full run of data grants.
  assign d_grant_c  = d_req && !(if_req && (run_cnt == RUN_MAX));
  assign lat_load_c = (state == ST_ISSUE) && mem_en && !mem_we;
  assign lat_dec_c  = (state == ST_WAIT);

  assign if_stall = if_req & ~if_done;
  assign d_stall  = d_req & ~d_done;

  lat_counter #(
    .W(LW)
  ) u_lat (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lat_load_c),
    .load_val (LAT_LOAD),
    .dec      (lat_dec_c),
    .zero_c   (lat_zero_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      owner     <= OWNER_IF;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      run_cnt   <= '0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!if_req) run_cnt <= '0;
          if (d_grant_c) begin
            if (if_req && (run_cnt != RUN_MAX)) run_cnt <= run_cnt + RW'(1);
            owner     <= OWNER_D;
            mem_en    <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            state     <= ST_ISSUE;
          end else if (if_req) begin
            run_cnt  <= '0;
            owner    <= OWNER_IF;
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (mem_we) begin
            state <= ST_RESP;
            if (owner == OWNER_D) d_done <= 1'b1;
            else                  if_done <= 1'b1;
          end else if (MEM_LAT > 1) begin
            state <= ST_WAIT;
          end else if (!mem_en) begin
            // Single-cycle latency: second ISSUE cycle is when read data is valid.
            state <= ST_RESP;
            if (owner == OWNER_D) begin
              d_rdata <= mem_rdata;
              d_done  <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_done  <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (lat_zero_c) begin
            state <= ST_RESP;
            if (owner == OWNER_D) begin
              d_rdata <= mem_rdata;
              d_done  <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_done  <= 1'b1;
            end
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model of grants, latencies and memory contents.
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 8;
  localparam int unsigned DW   = 32;
  localparam int          LAT  = 2;
  localparam int          MAXR = 4;

  logic clk = 1'b0;
  logic rst_n;

  logic          if_req, if_done, if_stall, d_req, d_we, d_done, d_stall;
  logic          mem_en, mem_we, owner;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [DW-1:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;

  logic          if_req_1, if_done_1, if_stall_1, d_req_1, d_we_1, d_done_1, d_stall_1;
  logic          mem_en_1, mem_we_1, owner_1;
  logic [AW-1:0] if_addr_1, d_addr_1, mem_addr_1;
  logic [DW-1:0] if_rdata_1, d_wdata_1, d_rdata_1, mem_wdata_1, mem_rdata_1;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .MAX_D_RUN(MAXR)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .MAX_D_RUN(MAXR)) u_dut_lat1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req_1), .if_addr(if_addr_1), .if_done(if_done_1), .if_rdata(if_rdata_1),
    .if_stall(if_stall_1),
    .d_req(d_req_1), .d_we(d_we_1), .d_addr(d_addr_1), .d_wdata(d_wdata_1),
    .d_done(d_done_1), .d_rdata(d_rdata_1), .d_stall(d_stall_1),
    .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
    .mem_rdata(mem_rdata_1), .owner(owner_1)
  );

  function automatic logic [DW-1:0] seed(input logic [AW-1:0] a);
    return {a ^ 8'hA5, ~a, a + 8'h3C, a};
  endfunction

  // Memory devices: junk on the read bus except exactly LAT cycles after a read strobe.
  bit   [DW-1:0] dev_x [256];
  logic [DW-1:0] pipe  [LAT];
  always @(posedge clk) begin
    if (mem_en && mem_we) dev_x[mem_addr] <= mem_wdata ^ seed(mem_addr);
    pipe[0] <= (mem_en && !mem_we) ? (dev_x[mem_addr] ^ seed(mem_addr)) : DW'($urandom);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  logic [DW-1:0] pipe_1;
  always @(posedge clk) pipe_1 <= (mem_en_1 && !mem_we_1) ? seed(mem_addr_1) : DW'($urandom);
  assign mem_rdata_1 = pipe_1;

  // Reference model state.
  bit            ref_wr [256];
  logic [DW-1:0] ref_val [256];
  int            total = 0, bad = 0, cyc = 0;
  bit            m_act = 1'b0, m_own, m_we, e_ifd, e_dd;
  int            m_gc, m_dc, m_run = 0;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd, m_rd;
  logic [DW-1:0] e_if_rd = '0, e_d_rd = '0;
  int            last_men = -1, last_ifd = -1, last_dd = -1, n_dd = 0, n_ifd = 0;
  logic [AW-1:0] last_men_addr;
  int            ifd_nd [$];

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_wr[a] ? ref_val[a] : seed(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic grant(input bit own, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    m_act = 1'b1; m_own = own; m_we = we; m_addr = a; m_wd = wd; m_gc = cyc;
    m_dc  = cyc + (we ? 2 : 2 + LAT);
    if (we) begin
      ref_wr[a]  = 1'b1;
      ref_val[a] = wd;
    end else begin
      m_rd = ref_read(a);
    end
  endtask

  // Arbitration decision for the requests sampled at the coming edge.
  task automatic model_sample();
    if (m_act && cyc > m_dc) m_act = 1'b0;
    if (!m_act) begin
      if (!if_req) m_run = 0;
      if (d_req && !(if_req && m_run == MAXR)) begin
        if (if_req && m_run < MAXR) m_run++;
        grant(1'b1, d_we, d_addr, d_wdata);
      end else if (if_req) begin
        m_run = 0;
        grant(1'b0, 1'b0, if_addr, '0);
      end
    end
  endtask

  task automatic check_cycle();
    bit e_men, in_acc;
    e_men  = m_act && (cyc == m_gc + 1);
    in_acc = m_act && (cyc > m_gc) && (cyc <= m_dc);
    e_ifd  = m_act && (cyc == m_dc) && !m_own;
    e_dd   = m_act && (cyc == m_dc) && m_own;
    if (e_ifd) e_if_rd = m_rd;
    if (e_dd && !m_we) e_d_rd = m_rd;
    chk("mem_en", 32'(mem_en), 32'(e_men));
    if (e_men) begin
      chk("mem_we", 32'(mem_we), 32'(m_we));
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      if (m_we) chk("mem_wdata", mem_wdata, m_wd);
    end
    chk("if_done", 32'(if_done), 32'(e_ifd));
    chk("d_done", 32'(d_done), 32'(e_dd));
    chk("if_rdata", if_rdata, e_if_rd);
    chk("d_rdata", d_rdata, e_d_rd);
    chk("if_stall", 32'(if_stall), 32'(if_req & ~e_ifd));
    chk("d_stall", 32'(d_stall), 32'(d_req & ~e_dd));
    if (in_acc) chk("owner", 32'(owner), 32'(m_own));
    if (mem_en) begin last_men = cyc; last_men_addr = mem_addr; end
    if (if_done) begin last_ifd = cyc; n_ifd++; ifd_nd.push_back(n_dd); end
    if (d_done) begin last_dd = cyc; n_dd++; end
  endtask

  task automatic tick();
    model_sample();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_cycle();
  endtask

  // Requesters: after done, re-request with probability p, else drop; idle ones may start.
  task automatic drive(input int p_if, input int p_d);
    if (e_ifd) begin
      if_req  = (int'($urandom_range(0, 99)) < p_if);
      if_addr = AW'($urandom);
    end else if (!if_req && int'($urandom_range(0, 99)) < p_if) begin
      if_req  = 1'b1;
      if_addr = AW'($urandom);
    end
    if (e_dd) begin
      d_req   = (int'($urandom_range(0, 99)) < p_d);
      d_we    = 1'($urandom_range(0, 1));
      d_addr  = AW'($urandom);
      d_wdata = DW'($urandom);
    end else if (!d_req && int'($urandom_range(0, 99)) < p_d) begin
      d_req   = 1'b1;
      d_we    = 1'($urandom_range(0, 1));
      d_addr  = AW'($urandom);
      d_wdata = DW'($urandom);
    end
  endtask

  task automatic run(input int n, input int p_if, input int p_d);
    repeat (n) begin
      tick();
      drive(p_if, p_d);
    end
  endtask

  task automatic lat1_access(input bit fetch, input logic [AW-1:0] a,
                             output int done_at, output int men_n, output int wrong,
                             output logic [DW-1:0] rd);
    done_at = -1; men_n = 0; wrong = 0; rd = '0;
    if (fetch) begin if_req_1 = 1'b1; if_addr_1 = a; end
    else begin d_req_1 = 1'b1; d_we_1 = 1'b0; d_addr_1 = a; end
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_en_1) men_n++;
      if (fetch ? d_done_1 : if_done_1) wrong++;
      if (fetch ? if_done_1 : d_done_1) begin
        done_at = k;
        rd = fetch ? if_rdata_1 : d_rdata_1;
        if_req_1 = 1'b0;
        d_req_1  = 1'b0;
      end
    end
  endtask

  initial begin
    int t0, n0, done_at, men_n, wrong;
    logic [DW-1:0] rd;

    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    if_req_1 = 1'b0; if_addr_1 = '0; d_req_1 = 1'b0; d_we_1 = 1'b0; d_addr_1 = '0; d_wdata_1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_done", 32'({if_done, d_done}), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", if_rdata | d_rdata, 32'd0);
    rst_n = 1'b1;
    run(2, 0, 0);

    // Store 5 to 0x20.
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 32'h5; t0 = cyc; n0 = n_ifd;
    run(4, 0, 0);
    chk("st_men_cyc", 32'(last_men - t0), 32'd1);
    chk("st_men_addr", 32'(last_men_addr), 32'h20);
    chk("st_done_cyc", 32'(last_dd - t0), 32'd2);
    chk("st_no_if_done", 32'(n_ifd - n0), 32'd0);

    // Seed 0x10 with DEADBEEF, then fetch it.
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h10; d_wdata = 32'hDEADBEEF;
    run(4, 0, 0);
    if_req = 1'b1; if_addr = 8'h10; t0 = cyc;
    run(6, 0, 0);
    chk("if_men_cyc", 32'(last_men - t0), 32'd1);
    chk("if_men_addr", 32'(last_men_addr), 32'h10);
    chk("if_done_cyc", 32'(last_ifd - t0), 32'd4);
    chk("if_rdata_val", if_rdata, 32'hDEADBEEF);

    // Contention: data read wins, fetch follows in the next IDLE.
    if_req = 1'b1; if_addr = 8'h44; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10; t0 = cyc;
    run(12, 0, 0);
    chk("ct_d_done_cyc", 32'(last_dd - t0), 32'd4);
    chk("ct_d_rdata", d_rdata, 32'hDEADBEEF);
    chk("ct_if_men_cyc", 32'(last_men - t0), 32'd6);
    chk("ct_if_men_addr", 32'(last_men_addr), 32'h44);
    chk("ct_if_done_cyc", 32'(last_ifd - t0), 32'd9);

    // Starvation guard: both requesters continuously busy.
    ifd_nd.delete();
    n0 = n_dd;
    if_req = 1'b1; if_addr = 8'h60; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
    run(55, 100, 100);
    chk("sv_two_fetches", 32'(ifd_nd.size() >= 2), 32'd1);
    if (ifd_nd.size() >= 2) begin
      chk("sv_run1", 32'(ifd_nd[0] - n0), 32'(MAXR));
      chk("sv_run2", 32'(ifd_nd[1] - ifd_nd[0]), 32'(MAXR));
    end
    run(15, 0, 0);

    // Reset during WAIT of a fetch read; late read data must be ignored.
    if_req = 1'b1; if_addr = 8'h10; t0 = cyc;
    run(2, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("mr_mem_en", 32'(mem_en), 32'd0);
    chk("mr_owner", 32'(owner), 32'd0);
    chk("mr_done", 32'({if_done, d_done}), 32'd0);
    chk("mr_rdata", if_rdata | d_rdata, 32'd0);
    if_req = 1'b0;
    repeat (3) begin @(posedge clk); cyc++; end
    @(negedge clk);
    rst_n = 1'b1;
    m_act = 1'b0; m_run = 0; e_if_rd = '0; e_d_rd = '0;
    run(4, 0, 0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20; t0 = cyc;
    run(8, 0, 0);
    chk("mr_after_done", 32'(last_dd - t0), 32'd4);
    chk("mr_after_data", d_rdata, 32'h5);
    chk("mr_if_rdata_clear", if_rdata, 32'd0);

    // Random traffic.
    run(800, 35, 45);
    run(20, 0, 0);

    // Single-cycle latency instance.
    lat1_access(1'b0, 8'h03, done_at, men_n, wrong, rd);
    chk("l1_ld_done_cyc", 32'(done_at), 32'd3);
    chk("l1_ld_data", rd, seed(8'h03));
    chk("l1_ld_men", 32'(men_n), 32'd1);
    chk("l1_ld_no_if_done", 32'(wrong), 32'd0);
    lat1_access(1'b1, 8'h07, done_at, men_n, wrong, rd);
    chk("l1_if_done_cyc", 32'(done_at), 32'd3);
    chk("l1_if_data", rd, seed(8'h07));
    chk("l1_if_no_d_done", 32'(wrong), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-ported unified memory between instruction fetch (IF) and the data-memory stage (load, store, jump-memory). The block grants one requester at a time and sequences the fixed-latency memory access. It returns read data with a one-cycle done pulse and drives the stall signals the pipeline uses to freeze IF or MEM. Data requests have priority, and a run-length guard stops fetch from being starved.

Parameters:
AW, 8, address width
DW, 32, data width
MEM_LAT, 2, cycles from mem_en to valid mem_rdata (>=1)
MAX_D_RUN, 4, max consecutive data grants while if_req is pending (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch read request; held until if_done
if_addr  in  AW  fetch address (PC)
if_done  out  1  one-cycle pulse, if_rdata valid
if_rdata  out  DW  fetched instruction
if_stall  out  1  if_req & ~if_done (combinational)
d_req  in  1  data request (memRead or memWrite)
d_we  in  1  1 = store, 0 = load / jump-memory read
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_done  out  1  one-cycle pulse: read data valid, or write committed
d_rdata  out  DW  loaded data
d_stall  out  1  d_req & ~d_done (combinational)
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  write enable, qualified by mem_en
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en
owner  out  1  0 = fetch, 1 = data; meaningful only when not IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; mem_en, mem_we, if_done, d_done, owner = 0.
  - mem_addr, mem_wdata, if_rdata, d_rdata = 0; run counter = 0; latency counter = 0.
  - Reset mid-access abandons the access; a late mem_rdata is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP. All mem_* and *_done/*_rdata outputs are registered.
- IDLE:
  - Requests are sampled at the clock edge.
  - Grant goes to data if d_req, unless run_cnt==MAX_D_RUN and if_req, in which case fetch wins.
  - With no requests, stay in IDLE.
  - On grant, latch addr, we and wdata into mem_*, set owner, go to ISSUE.
- ISSUE (one cycle): mem_en=1.
  - Write: go to RESP.
  - Read: load lat_cnt=MEM_LAT-1, go to WAIT if MEM_LAT>1, else capture mem_rdata on the next edge and go to RESP.
- WAIT: mem_en=0. Decrement lat_cnt. When lat_cnt==0, capture mem_rdata into the owner's rdata register and go to RESP.
- RESP (one cycle): owner's done=1; go to IDLE.
- Latency, from request sampled in IDLE (cycle 0):
  - Read: done in cycle 2+MEM_LAT.
  - Write: done in cycle 2.
  - Back-to-back accesses are therefore separated by at least one IDLE cycle.
- run_cnt:
  - Increments on each data grant while if_req=1, saturating at MAX_D_RUN.
  - Clears on a fetch grant, or in IDLE when if_req=0.
- Requester rules:
  - req, addr, we and wdata stay stable from assertion until done.
  - req drops in the cycle after done, or stays high to request again.
  - The arbiter does not sample req outside IDLE.
- A simultaneous if_req and d_req with run_cnt<MAX_D_RUN gives data the grant; if_stall stays high throughout.
- The unselected rdata register holds its previous value; done is never asserted for the non-owner.
- Address width wraps naturally; no range checking is done.

Decomposition:
- Shared package cpu_pkg holds:
  - arbiter state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3);
  - OWNER_IF=1'b0, OWNER_D=1'b1;
  - default AW and DW, shared with control and the datapath.
- One natural sub-module, lat_counter: a loadable down-counter with a zero flag, parameterised by MEM_LAT width. Everything else is flat.

Test Plan:
- Single fetch: if_req=1, if_addr=8'h10, MEM_LAT=2, memory returns 32'hDEADBEEF → mem_en in cycle 1 with addr 8'h10, if_done and if_rdata=32'hDEADBEEF in cycle 4, if_stall high in cycles 0-3.
- Store: d_req=1, d_we=1, d_addr=8'h20, d_wdata=32'h5 → mem_en=mem_we=1 in cycle 1 with addr 8'h20 and wdata 5, d_done in cycle 2, if_done never set.
- Contention: if_req and d_req both high from cycle 0, d_we=0 → data is granted first (owner=1), and the fetch grant occurs in the IDLE that follows d_done.
- Starvation guard: MAX_D_RUN=4, d_req held continuously with if_req=1 → exactly 4 data accesses, then 1 fetch, then data resumes; run_cnt returns to 0 after the fetch.
- Reset mid-read: assert rst_n=0 during WAIT → mem_en, owner and done are 0 immediately. After release, the next request completes normally, and a late mem_rdata never appears on if_rdata or d_rdata.
- MEM_LAT=1 build: load from 8'h3 → d_done in cycle 3 with the correct data, and WAIT is never entered.
